smaesh_reseed_scheduler: RTL and testbench

SMAESH_RESEED_SCHEDULER -- requirements
Module: smaesh_reseed_scheduler

---
 rtl/smaesh_pkg.sv | 14 +
 rtl/smaesh_reseed_counter.sv | 55 +++++
 rtl/smaesh_reseed_scheduler.sv | 125 ++++++++++++
 tb/tb_smaesh_reseed_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/smaesh_pkg.sv
// Shared definitions for the SMAESH reseed scheduler: state encoding and
// the default width of the per-seed transaction counter.
package smaesh_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_UNSEEDED  = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_SEED = 2'd2,
        ST_RESEEDING = 2'd3
    } state_t;

endpackage

// File: rtl/smaesh_reseed_counter.sv
// Transaction counter with captured limit: load/clear/saturating increment,
// plus a look-ahead flag raised when the current increment reaches the limit.
module smaesh_reseed_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit_in,
    output logic [CNT_W-1:0] count,
    output logic             limit_hit
);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] limit_r;
    logic [CNT_W-1:0] count_inc_s;

    // Saturating increment and limit look-ahead (a zero limit never hits)
    always_comb begin
        count_inc_s = count_r;
        limit_hit   = 1'b0;
        if (count_r != {CNT_W{1'b1}}) begin
            count_inc_s = count_r + CNT_W'(1);
        end else begin
            count_inc_s = count_r;
        end
        if (inc && (limit_r != {CNT_W{1'b0}}) && (count_inc_s == limit_r)) begin
            limit_hit = 1'b1;
        end else begin
            limit_hit = 1'b0;
        end
    end

    // Counter and limit registers; load takes priority over clear and increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
            limit_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= {CNT_W{1'b0}};
            limit_r <= limit_in;
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_inc_s;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/smaesh_reseed_scheduler.sv
// Gates the host data stream into the masked AES core and demands a fresh
// PRNG seed after cfg_limit transactions. Optional SMAESH_RESEED_FORCE_EN adds force_reseed.
module smaesh_reseed_scheduler
    import smaesh_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cfg_limit,
    input  logic             up_data_valid,
    output logic             up_data_ready,
    output logic             dn_data_valid,
    input  logic             dn_data_ready,
    input  logic             seed_valid,
    input  logic             seed_ready,
    input  logic             prng_busy,
    input  logic             prng_seeded,
`ifdef SMAESH_RESEED_FORCE_EN
    input  logic             force_reseed,
`endif
    output logic             reseed_req,
    output logic [CNT_W-1:0] enc_count
);

    state_t state_r;
    state_t state_next_s;
    logic   run_s;
    logic   dh_s;
    logic   sh_s;
    logic   force_s;
    logic   limit_hit_s;
    logic   load_s;
    logic   clear_s;
    logic   inc_s;
    logic   reseed_req_r;

`ifdef SMAESH_RESEED_FORCE_EN
    assign force_s = force_reseed;
`else
    assign force_s = 1'b0;
`endif

    assign run_s         = (state_r == ST_RUN);
    assign dn_data_valid = up_data_valid & run_s;
    assign up_data_ready = dn_data_ready & run_s;
    assign dh_s          = dn_data_valid & dn_data_ready;
    assign sh_s          = seed_valid & seed_ready;

    // A seed handshake in RUN wins over a coincident data handshake
    assign load_s  = (state_next_s == ST_RUN) && (state_r != ST_RUN);
    assign clear_s = run_s & sh_s;
    assign inc_s   = dh_s & ~sh_s;

    smaesh_reseed_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .clear     (clear_s),
        .inc       (inc_s),
        .limit_in  (cfg_limit),
        .count     (enc_count),
        .limit_hit (limit_hit_s)
    );

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNSEEDED: begin
                if (sh_s) begin
                    state_next_s = ST_RESEEDING;
                end else if (prng_seeded && !prng_busy) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_UNSEEDED;
                end
            end
            ST_RUN: begin
                if (sh_s) begin
                    state_next_s = ST_RESEEDING;
                end else if (force_s || limit_hit_s) begin
                    state_next_s = ST_WAIT_SEED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_WAIT_SEED: begin
                if (sh_s) begin
                    state_next_s = ST_RESEEDING;
                end else begin
                    state_next_s = ST_WAIT_SEED;
                end
            end
            ST_RESEEDING: begin
                if (prng_busy) begin
                    state_next_s = ST_RESEEDING;
                end else if (prng_seeded) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_UNSEEDED;
                end
            end
            default: begin
                state_next_s = ST_UNSEEDED;
            end
        endcase
    end

    // State register and registered reseed request (high exactly in WAIT_SEED)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_UNSEEDED;
            reseed_req_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            reseed_req_r <= (state_next_s == ST_WAIT_SEED);
        end
    end

    assign reseed_req = reseed_req_r;

endmodule

// File: tb/tb_smaesh_reseed_scheduler.sv
// Directed self-checking bench for smaesh_reseed_scheduler (CNT_W = 16).
module tb_smaesh_reseed_scheduler;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CNT_W-1:0] cfg_limit = 16'd0;
    logic             up_data_valid = 1'b0;
    logic             up_data_ready;
    logic             dn_data_valid;
    logic             dn_data_ready = 1'b0;
    logic             seed_valid = 1'b0;
    logic             seed_ready = 1'b0;
    logic             prng_busy = 1'b0;
    logic             prng_seeded = 1'b0;
`ifdef SMAESH_RESEED_FORCE_EN
    logic             force_reseed = 1'b0;
`endif
    logic             reseed_req;
    logic [CNT_W-1:0] enc_count;

    int checks = 0;
    int errors = 0;
    int dh_cnt;
    int rr_hits;

    smaesh_reseed_scheduler #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_limit     (cfg_limit),
        .up_data_valid (up_data_valid),
        .up_data_ready (up_data_ready),
        .dn_data_valid (dn_data_valid),
        .dn_data_ready (dn_data_ready),
        .seed_valid    (seed_valid),
        .seed_ready    (seed_ready),
        .prng_busy     (prng_busy),
        .prng_seeded   (prng_seeded),
`ifdef SMAESH_RESEED_FORCE_EN
        .force_reseed  (force_reseed),
`endif
        .reseed_req    (reseed_req),
        .enc_count     (enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with inputs asserted: everything must stay quiet
        prng_seeded   = 1'b1;
        cfg_limit     = 16'd3;
        up_data_valid = 1'b1;
        dn_data_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_enc_count", 32'(enc_count), 32'd0);
        check("rst_reseed_req", 32'(reseed_req), 32'd0);
        check("rst_up_ready", 32'(up_data_ready), 32'd0);
        check("rst_dn_valid", 32'(dn_data_valid), 32'd0);

        // Limit of 3: exactly three handshakes then WAIT_SEED
        rst = 1'b0;
        #1;
        check("unseeded_dn_valid", 32'(dn_data_valid), 32'd0);
        tick();
        dh_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            check("run_dn_valid", 32'(dn_data_valid), 32'd1);
            check("run_count", 32'(enc_count), 32'(i));
            if (dn_data_valid && dn_data_ready) dh_cnt++;
            tick();
        end
        check("lim_reseed_req", 32'(reseed_req), 32'd1);
        check("lim_enc_count", 32'(enc_count), 32'd3);
        check("lim_up_ready", 32'(up_data_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (dn_data_valid && dn_data_ready) dh_cnt++;
            tick();
        end
        check("lim_dh_total", 32'(dh_cnt), 32'd3);
        check("wait_reseed_req", 32'(reseed_req), 32'd1);

        // Seed handshake with PRNG busy for four cycles
        seed_valid = 1'b1; seed_ready = 1'b1; prng_busy = 1'b1;
        tick();
        seed_valid = 1'b0; seed_ready = 1'b0;
        check("resd_reseed_req", 32'(reseed_req), 32'd0);
        check("resd_dn_valid", 32'(dn_data_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_dn_valid", 32'(dn_data_valid), 32'd0);
        end
        cfg_limit = 16'd2;
        prng_busy = 1'b0;
        #1;
        check("resd_last_dn_valid", 32'(dn_data_valid), 32'd0);
        tick();
        check("rerun_enc_count", 32'(enc_count), 32'd0);
        check("rerun_dn_valid", 32'(dn_data_valid), 32'd1);
        check("rerun_up_ready", 32'(up_data_ready), 32'd1);
        check("rerun_reseed_req", 32'(reseed_req), 32'd0);
        cfg_limit = 16'd7;  // ignored while in RUN
        tick(); tick();
        check("lim2_reseed_req", 32'(reseed_req), 32'd1);
        check("lim2_enc_count", 32'(enc_count), 32'd2);

        // Seed and data handshake in the same cycle at enc_count=1
        cfg_limit = 16'd0;
        seed_valid = 1'b1; seed_ready = 1'b1;
        tick();
        seed_valid = 1'b0; seed_ready = 1'b0;
        tick();
        check("run0_enc_count", 32'(enc_count), 32'd0);
        tick();
        check("run0_count1", 32'(enc_count), 32'd1);
        seed_valid = 1'b1; seed_ready = 1'b1;
        #1;
        check("coll_dn_valid", 32'(dn_data_valid), 32'd1);
        tick();
        seed_valid = 1'b0; seed_ready = 1'b0;
        check("coll_enc_count", 32'(enc_count), 32'd0);
        check("coll_dn_valid_after", 32'(dn_data_valid), 32'd0);
        tick();
        check("coll_rerun_dn_valid", 32'(dn_data_valid), 32'd1);
        check("coll_rerun_count", 32'(enc_count), 32'd0);

        // Unlimited: 70000 handshakes saturate the counter, no reseed request
        rr_hits = 0;
        for (int i = 0; i < 70000; i++) begin
            tick();
            if (reseed_req) rr_hits++;
            if (i == 999) check("unl_count_1000", 32'(enc_count), 32'd1000);
        end
        check("unl_reseed_hits", 32'(rr_hits), 32'd0);
        check("unl_enc_count", 32'(enc_count), 32'h0000FFFF);
        check("unl_dn_valid", 32'(dn_data_valid), 32'd1);

        // Reseed that ends without a valid seed falls back to UNSEEDED
        prng_seeded = 1'b0;
        seed_valid = 1'b1; seed_ready = 1'b1;
        tick();
        seed_valid = 1'b0; seed_ready = 1'b0;
        tick();
        tick();
        check("unseed_dn_valid", 32'(dn_data_valid), 32'd0);
        cfg_limit = 16'd1;
        prng_seeded = 1'b1;
        tick();
        check("unseed_rerun_dn_valid", 32'(dn_data_valid), 32'd1);
        check("unseed_rerun_count", 32'(enc_count), 32'd0);

        // Reset while waiting for a seed
        tick();
        check("w1_reseed_req", 32'(reseed_req), 32'd1);
        check("w1_enc_count", 32'(enc_count), 32'd1);
        #2;
        rst = 1'b1;
        prng_seeded = 1'b0;
        #1;
        check("arst_reseed_req", 32'(reseed_req), 32'd0);
        check("arst_enc_count", 32'(enc_count), 32'd0);
        check("arst_up_ready", 32'(up_data_ready), 32'd0);
        check("arst_dn_valid", 32'(dn_data_valid), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_dn_valid", 32'(dn_data_valid), 32'd0);
            check("post_rst_reseed_req", 32'(reseed_req), 32'd0);
        end
        cfg_limit = 16'd0;
        prng_seeded = 1'b1;
        tick();
        check("post_rst_run", 32'(dn_data_valid), 32'd1);

`ifdef SMAESH_RESEED_FORCE_EN
        // Forced reseed at enc_count=5
        for (int i = 0; i < 5; i++) tick();
        check("frc_count5", 32'(enc_count), 32'd5);
        up_data_valid = 1'b0;
        force_reseed = 1'b1;
        tick();
        force_reseed = 1'b0;
        check("frc_reseed_req", 32'(reseed_req), 32'd1);
        check("frc_enc_count", 32'(enc_count), 32'd5);
        check("frc_up_ready", 32'(up_data_ready), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
